// File: rtl/fu_issue_scoreboard_pkg.sv
// Shared types for the functional-unit issue scoreboard: FU index type,
// captured destination record and the FU index constants.
package fu_issue_scoreboard_pkg;

    localparam int unsigned SB_NUM_FU = 9;
    localparam int unsigned SB_FU_W   = $clog2(SB_NUM_FU);

    typedef logic [SB_FU_W-1:0] fu_idx_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       fp;
        logic       wr;
    } sb_dest_t;

    localparam fu_idx_t FU_ALU   = fu_idx_t'(0);
    localparam fu_idx_t FU_MUL   = fu_idx_t'(1);
    localparam fu_idx_t FU_BR    = fu_idx_t'(2);
    localparam fu_idx_t FU_DIV   = fu_idx_t'(3);
    localparam fu_idx_t FU_FADD  = fu_idx_t'(4);
    localparam fu_idx_t FU_FMUL  = fu_idx_t'(5);
    localparam fu_idx_t FU_FDIV  = fu_idx_t'(6);
    localparam fu_idx_t FU_FSQRT = fu_idx_t'(7);
    localparam fu_idx_t FU_R4    = fu_idx_t'(8);

    // Int x0 is hardwired, so a write to it never occupies a pending bit.
    function automatic logic dest_tracked(input sb_dest_t d);
        return d.wr & (d.fp | (d.rd != 5'd0));
    endfunction

endpackage

// File: rtl/fu_issue_scoreboard_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping.
module fu_issue_scoreboard_rr_arbiter #(
    parameter  int unsigned N = 9,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    int unsigned j;
    logic [W-1:0] jj;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N)
                j = j - N;
            jj = W'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/fu_issue_scoreboard.sv
// Issue scoreboard for non-pipelined EXE units with round-robin writeback arbitration.
// Optional SB_RELEASE_BYPASS_EN: the FU/register released by the active grant is free for issue that cycle.
module fu_issue_scoreboard
    import fu_issue_scoreboard_pkg::*;
#(
    parameter  int unsigned NUM_FU   = 9,
    parameter  int unsigned NUM_REGS = 32,
    localparam int unsigned FU_W     = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [FU_W-1:0]   issue_fu,
    input  logic              issue_wr,
    input  logic [4:0]        issue_rd,
    input  logic              issue_rd_fp,
    input  logic [4:0]        issue_rs1,
    input  logic              issue_rs1_fp,
    input  logic              issue_use1,
    input  logic [4:0]        issue_rs2,
    input  logic              issue_rs2_fp,
    input  logic              issue_use2,
    input  logic [4:0]        issue_rs3,
    input  logic              issue_rs3_fp,
    input  logic              issue_use3,
    input  logic              stall_pipl,
    output logic              issue_stall,
    input  logic [NUM_FU-1:0] fu_done,
    input  logic [NUM_FU-1:0] fu_kill,
    output logic [NUM_FU-1:0] wb_grant,
    output logic              wb_valid,
    output logic [FU_W-1:0]   wb_sel,
    output logic [4:0]        wb_rd,
    output logic              wb_rd_fp,
    output logic              wb_wr,
    output logic [NUM_FU-1:0] fu_busy
);

    logic [1:0][NUM_REGS-1:0] pending;
    logic [1:0][NUM_REGS-1:0] pend_view;
    logic [NUM_FU-1:0]        busy_view;
    sb_dest_t                 dest_q [NUM_FU];
    sb_dest_t                 issue_dest;
    logic [FU_W-1:0]          rr_ptr;

    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] arb_gnt;
    logic [FU_W-1:0]   arb_idx;
    logic              arb_any;
    logic              raw, waw, fire, grant_now;

    function automatic logic src_haz(input logic [1:0][NUM_REGS-1:0] p,
                                     input logic [4:0] r, input logic fp, input logic used);
        return used & (fp | (r != 5'd0)) & p[fp][r];
    endfunction

    always_comb begin
        busy_view = fu_busy;
        pend_view = pending;
`ifdef SB_RELEASE_BYPASS_EN
        busy_view = fu_busy & ~wb_grant;
        if (wb_valid && wb_wr)
            pend_view[wb_rd_fp][wb_rd] = 1'b0;
`endif
    end

    assign issue_dest  = '{rd: issue_rd, fp: issue_rd_fp, wr: issue_wr};
    assign raw         = src_haz(pend_view, issue_rs1, issue_rs1_fp, issue_use1)
                       | src_haz(pend_view, issue_rs2, issue_rs2_fp, issue_use2)
                       | src_haz(pend_view, issue_rs3, issue_rs3_fp, issue_use3);
    assign waw         = dest_tracked(issue_dest) & pend_view[issue_rd_fp][issue_rd];
    assign issue_stall = issue_valid & (busy_view[issue_fu] | raw | waw);
    assign fire        = issue_valid & ~issue_stall & ~stall_pipl;

    assign cand      = fu_done & fu_busy & ~fu_kill & ~wb_grant;
    assign grant_now = arb_any & ~stall_pipl;

    fu_issue_scoreboard_rr_arbiter #(.N(NUM_FU)) u_arb (
        .req (cand),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            fu_busy  <= '0;
            wb_grant <= '0;
            wb_valid <= 1'b0;
            wb_sel   <= '0;
            wb_rd    <= '0;
            wb_rd_fp <= 1'b0;
            wb_wr    <= 1'b0;
            rr_ptr   <= '0;
            for (int unsigned i = 0; i < NUM_FU; i++)
                dest_q[i] <= '0;
        end else begin
            assert ((fu_done & ~fu_busy) == '0)
                else $error("fu_done raised on an idle functional unit");

            wb_grant <= '0;
            wb_valid <= 1'b0;
            wb_sel   <= '0;
            wb_rd    <= '0;
            wb_rd_fp <= 1'b0;
            wb_wr    <= 1'b0;
            if (grant_now) begin
                wb_grant <= arb_gnt;
                wb_valid <= 1'b1;
                wb_sel   <= arb_idx;
                wb_rd    <= dest_q[arb_idx].rd;
                wb_rd_fp <= dest_q[arb_idx].fp;
                wb_wr    <= dest_q[arb_idx].wr;
                rr_ptr   <= (arb_idx == FU_W'(NUM_FU - 1)) ? '0 : arb_idx + 1'b1;
            end

            // Release happens at the end of the grant cycle; the issue set below
            // comes last so a same-edge reissue or register reuse keeps the new owner.
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (wb_grant[i] || (fu_kill[i] && fu_busy[i])) begin
                    fu_busy[i] <= 1'b0;
                    if (dest_tracked(dest_q[i]))
                        pending[dest_q[i].fp][dest_q[i].rd] <= 1'b0;
                end
            end

            if (fire) begin
                fu_busy[issue_fu] <= 1'b1;
                dest_q[issue_fu]  <= issue_dest;
                if (dest_tracked(issue_dest))
                    pending[issue_rd_fp][issue_rd] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fu_issue_scoreboard.sv
// Directed self-checking bench for fu_issue_scoreboard (default 9 FUs, 32 regs).
module tb_fu_issue_scoreboard;
    import fu_issue_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [3:0] issue_fu;
    logic       issue_wr;
    logic [4:0] issue_rd;
    logic       issue_rd_fp;
    logic [4:0] issue_rs1, issue_rs2, issue_rs3;
    logic       issue_rs1_fp, issue_rs2_fp, issue_rs3_fp;
    logic       issue_use1, issue_use2, issue_use3;
    logic       stall_pipl;
    logic       issue_stall;
    logic [8:0] fu_done, fu_kill, wb_grant, fu_busy;
    logic       wb_valid;
    logic [3:0] wb_sel;
    logic [4:0] wb_rd;
    logic       wb_rd_fp, wb_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fu_issue_scoreboard #(.NUM_FU(9), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_rd_fp(issue_rd_fp),
        .issue_rs1(issue_rs1), .issue_rs1_fp(issue_rs1_fp), .issue_use1(issue_use1),
        .issue_rs2(issue_rs2), .issue_rs2_fp(issue_rs2_fp), .issue_use2(issue_use2),
        .issue_rs3(issue_rs3), .issue_rs3_fp(issue_rs3_fp), .issue_use3(issue_use3),
        .stall_pipl(stall_pipl), .issue_stall(issue_stall),
        .fu_done(fu_done), .fu_kill(fu_kill), .wb_grant(wb_grant),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_rd(wb_rd),
        .wb_rd_fp(wb_rd_fp), .wb_wr(wb_wr), .fu_busy(fu_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_issue;
        issue_valid = 1'b0; issue_fu = '0; issue_wr = 1'b0;
        issue_rd = '0; issue_rd_fp = 1'b0;
        issue_rs1 = '0; issue_rs1_fp = 1'b0; issue_use1 = 1'b0;
        issue_rs2 = '0; issue_rs2_fp = 1'b0; issue_use2 = 1'b0;
        issue_rs3 = '0; issue_rs3_fp = 1'b0; issue_use3 = 1'b0;
    endtask

    task automatic set_issue(input logic [3:0] fu, input logic wr, input logic [4:0] rd, input logic rdfp);
        clr_issue;
        issue_valid = 1'b1; issue_fu = fu; issue_wr = wr;
        issue_rd = rd; issue_rd_fp = rdfp;
    endtask

    task automatic do_issue(input string tag, input logic [3:0] fu, input logic wr,
                            input logic [4:0] rd, input logic rdfp);
        set_issue(fu, wr, rd, rdfp);
        #1 chk(tag, 32'(issue_stall), 32'd0);
        tick;
        clr_issue;
    endtask

    task automatic retire(input string tag, input logic [3:0] fu, input logic [4:0] rd,
                          input logic rdfp, input logic wr);
        fu_done[fu] = 1'b1;
        tick;
        chk({tag, "_grant"}, 32'(wb_grant), 32'(1) << fu);
        chk({tag, "_rd"}, {25'd0, wb_rd, wb_rd_fp, wb_wr}, {25'd0, rd, rdfp, wr});
        fu_done[fu] = 1'b0;
        tick;
    endtask

    initial begin
        reset = 1'b1; stall_pipl = 1'b0; fu_done = '0; fu_kill = '0;
        clr_issue;
        @(negedge clk);
        tick;
        reset = 1'b0;
        chk("rst_busy", 32'(fu_busy), 32'd0);
        chk("rst_grant", 32'(wb_grant), 32'd0);
        chk("rst_wb", {22'd0, wb_valid, wb_sel, wb_rd, wb_wr}, 32'd0);
        chk("rst_stall", 32'(issue_stall), 32'd0);

        // 1: Div writes x5, then RAW / structural / unused-source checks
        do_issue("iss_div", FU_DIV, 1'b1, 5'd5, 1'b0);
        chk("busy_div", 32'(fu_busy), 32'h008);
        set_issue(FU_ALU, 1'b1, 5'd6, 1'b0); issue_rs1 = 5'd5; issue_use1 = 1'b1;
        #1 chk("raw_x5", 32'(issue_stall), 32'd1);
        issue_use1 = 1'b0;
        #1 chk("unused_src", 32'(issue_stall), 32'd0);
        set_issue(FU_DIV, 1'b0, 5'd0, 1'b0);
        #1 chk("struct_div", 32'(issue_stall), 32'd1);
        clr_issue;

        // 2: Div done -> grant next cycle, x5 consumer unstalls after release
        fu_done[3] = 1'b1;
        #1 chk("pre_grant", 32'(wb_grant), 32'd0);
        tick;
        chk("g3_grant", 32'(wb_grant), 32'h008);
        chk("g3_info", {22'd0, wb_valid, wb_sel, wb_rd, wb_wr}, {22'd0, 1'b1, 4'd3, 5'd5, 1'b1});
        fu_done[3] = 1'b0;
        set_issue(FU_ALU, 1'b1, 5'd6, 1'b0); issue_rs1 = 5'd5; issue_use1 = 1'b1;
`ifdef SB_RELEASE_BYPASS_EN
        #1 chk("x5_t1", 32'(issue_stall), 32'd0);
        tick;
        chk("g3_over", 32'(wb_valid), 32'd0);
`else
        #1 chk("x5_t1", 32'(issue_stall), 32'd1);
        tick;
        chk("g3_over", 32'(wb_valid), 32'd0);
        #1 chk("x5_t2", 32'(issue_stall), 32'd0);
        tick;
`endif
        clr_issue;
        chk("busy_alu", 32'(fu_busy), 32'h001);
        set_issue(FU_MUL, 1'b1, 5'd6, 1'b0);
        #1 chk("waw_x6", 32'(issue_stall), 32'd1);
        clr_issue;
        retire("ret_alu", FU_ALU, 5'd6, 1'b0, 1'b1);

        // x0 write is not tracked; FADD grant moves rr_ptr to 5
        do_issue("iss_x0", FU_FADD, 1'b1, 5'd0, 1'b0);
        set_issue(FU_MUL, 1'b1, 5'd0, 1'b0);
        #1 chk("waw_x0", 32'(issue_stall), 32'd0);
        clr_issue;
        retire("ret_fadd", FU_FADD, 5'd0, 1'b0, 1'b1);

        // 3: FU1, FU4, FU7 done together with rr_ptr=5 -> 7,1,4
        do_issue("iss_m1", FU_MUL, 1'b1, 5'd1, 1'b0);
        do_issue("iss_a4", FU_FADD, 1'b1, 5'd4, 1'b0);
        do_issue("iss_s7", FU_FSQRT, 1'b1, 5'd7, 1'b1);
        fu_done = 9'b0_1001_0010;
        tick;
        chk("rr_first", {27'd0, wb_sel, wb_rd_fp}, {27'd0, 4'd7, 1'b1});
        fu_done[7] = 1'b0;
        tick;
        chk("rr_second", {23'd0, wb_sel, wb_rd}, {23'd0, 4'd1, 5'd1});
        fu_done[1] = 1'b0;
        tick;
        chk("rr_third", {23'd0, wb_sel, wb_rd}, {23'd0, 4'd4, 5'd4});
        fu_done[4] = 1'b0;
        tick;
        chk("rr_done", {22'd0, wb_valid, fu_busy}, 32'd0);

        // rr_ptr must be 5: FU6 beats FU3
        do_issue("iss_d3", FU_DIV, 1'b0, 5'd0, 1'b0);
        do_issue("iss_f6", FU_FDIV, 1'b0, 5'd0, 1'b0);
        fu_done = 9'b0_0100_1000;
        tick;
        chk("ptr5_a", {27'd0, wb_sel, wb_wr}, {27'd0, 4'd6, 1'b0});
        fu_done[6] = 1'b0;
        tick;
        chk("ptr5_b", 32'(wb_sel), 32'd3);
        fu_done[3] = 1'b0;
        tick;

        // 4: FP f0 is tracked, int x0 is not
        do_issue("iss_f0", FU_FDIV, 1'b1, 5'd0, 1'b1);
        set_issue(FU_FADD, 1'b1, 5'd2, 1'b1); issue_rs2 = 5'd0; issue_rs2_fp = 1'b1; issue_use2 = 1'b1;
        #1 chk("raw_f0", 32'(issue_stall), 32'd1);
        set_issue(FU_ALU, 1'b1, 5'd3, 1'b0); issue_rs2 = 5'd0; issue_use2 = 1'b1;
        #1 chk("raw_x0", 32'(issue_stall), 32'd0);
        set_issue(FU_FMUL, 1'b1, 5'd0, 1'b1);
        #1 chk("waw_f0", 32'(issue_stall), 32'd1);
        clr_issue;
        retire("ret_f0", FU_FDIV, 5'd0, 1'b1, 1'b1);

        // 5: done and kill together -> no grant, busy and pending cleared
        do_issue("iss_b9", FU_BR, 1'b1, 5'd9, 1'b0);
        set_issue(FU_ALU, 1'b0, 5'd0, 1'b0); issue_rs3 = 5'd9; issue_use3 = 1'b1;
        #1 chk("raw_x9", 32'(issue_stall), 32'd1);
        clr_issue;
        fu_done[2] = 1'b1; fu_kill[2] = 1'b1;
        tick;
        chk("kill_grant", {22'd0, wb_valid, wb_grant}, 32'd0);
        chk("kill_busy", 32'(fu_busy), 32'd0);
        fu_done[2] = 1'b0; fu_kill[2] = 1'b0;
        set_issue(FU_ALU, 1'b0, 5'd0, 1'b0); issue_rs3 = 5'd9; issue_use3 = 1'b1;
        #1 chk("kill_x9", 32'(issue_stall), 32'd0);
        clr_issue;

        // 6: stall_pipl holds grant and issue for 3 cycles
        do_issue("iss_f12", FU_FDIV, 1'b1, 5'd12, 1'b0);
        stall_pipl = 1'b1; fu_done[6] = 1'b1;
        set_issue(FU_ALU, 1'b1, 5'd13, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("stall_nogrant", {22'd0, wb_valid, wb_grant}, 32'd0);
        end
        chk("stall_noissue", 32'(fu_busy), 32'h040);
        stall_pipl = 1'b0;
        clr_issue;
        tick;
        chk("stall_grant", 32'(wb_grant), 32'h040);
        chk("stall_rd", 32'(wb_rd), 32'd12);
        fu_done[6] = 1'b0;
        tick;
        chk("stall_free", 32'(fu_busy), 32'd0);

        // Mid-operation reset drops all tracking
        do_issue("iss_m20", FU_MUL, 1'b1, 5'd20, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_rst_busy", 32'(fu_busy), 32'd0);
        set_issue(FU_ALU, 1'b0, 5'd0, 1'b0); issue_rs1 = 5'd20; issue_use1 = 1'b1;
        #1 chk("mid_rst_x20", 32'(issue_stall), 32'd0);
        clr_issue;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
